slr_cross_stream: RTL and testbench

Valid/ready streaming successor to the plain register-pipeline SLR crossing. Carries a WIDTH-bit stream across an SLR boundary through a Laguna TX/RX register pair. Backpressure does not cross combinationally: a credit counter on the source side and a receive FIFO on the sink side provide it, and credits return through their own Laguna register pair. Used wherever an AXI-Stream-style interface must span SLRs at full clock rate.

---
 rtl/slr_cross_stream.sv | 138 +++++++++++++
 tb/tb_slr_cross_stream.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slr_cross_stream.sv
// Valid/ready stream across an SLR boundary: forward valid/data and backward credit pulses each pass
// through a Laguna TX/RX register pair, and a source-side credit counter sized to the sink FIFO
// provides backpressure without any combinational path crossing the boundary.
// Handshake: a beat transfers on a rising edge where valid && ready. Valid never waits on ready,
// and payload is held stable while valid is high and ready is low.
module slr_cross_stream #(
   parameter int WIDTH       = 16,
   parameter int REGS_BEFORE = 1,
   parameter int REGS_AFTER  = 1,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                            clk,
   input  logic                            sreset_n,
   input  logic [WIDTH-1:0]                s_data,
   input  logic                            s_valid,
   output logic                            s_ready,
   output logic [WIDTH-1:0]                m_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] credits
);

   localparam int L_F = REGS_BEFORE + 2 + REGS_AFTER;
   localparam int L_B = REGS_AFTER + 2 + REGS_BEFORE;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int PW  = AW + 1;

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("slr_cross_stream: FIFO_DEPTH must be a power of two and at least 2");
   end
   if ((REGS_BEFORE < 0) || (REGS_BEFORE > 4) || (REGS_AFTER < 0) || (REGS_AFTER > 4)) begin : g_bad_regs
      $error("slr_cross_stream: REGS_BEFORE and REGS_AFTER must be within 0..4");
   end

   logic             accept;
   logic             pop;
   logic             credit_ret;
   logic             fifo_wr;
   logic             fifo_empty;
   logic             fifo_full;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];

   // Index 0 is the stage input; index L_F (L_B) is the last register of the chain.
   logic [L_F:0]     fwd_v;
   logic [WIDTH-1:0] fwd_d [L_F+1];
   logic [L_B:0]     crd;

   assign s_ready  = sreset_n && (credits != '0);
   assign accept   = s_valid && s_ready;
   assign fwd_v[0] = accept;
   assign fwd_d[0] = s_data;

   for (genvar i = 0; i < L_F; i++) begin : g_fwd
      if ((i == REGS_BEFORE) || (i == REGS_BEFORE + 1)) begin : g_laguna
         (* USER_SLL_REG = "true" *) logic             v_q;
         (* USER_SLL_REG = "true" *) logic [WIDTH-1:0] d_q;
         always_ff @(posedge clk) begin
            if (!sreset_n) v_q <= 1'b0;
            else           v_q <= fwd_v[i];
            d_q <= fwd_d[i];
         end
         assign fwd_v[i+1] = v_q;
         assign fwd_d[i+1] = d_q;
      end else begin : g_pipe
         (* shreg_extract = "no" *) logic             v_q;
         (* shreg_extract = "no" *) logic [WIDTH-1:0] d_q;
         always_ff @(posedge clk) begin
            if (!sreset_n) v_q <= 1'b0;
            else           v_q <= fwd_v[i];
            d_q <= fwd_d[i];
         end
         assign fwd_v[i+1] = v_q;
         assign fwd_d[i+1] = d_q;
      end
   end

   // Sink side drives the credit chain, so its Laguna pair sits after the REGS_AFTER stages.
   assign crd[0] = pop;

   for (genvar j = 0; j < L_B; j++) begin : g_bwd
      if ((j == REGS_AFTER) || (j == REGS_AFTER + 1)) begin : g_laguna
         (* USER_SLL_REG = "true" *) logic c_q;
         always_ff @(posedge clk) begin
            if (!sreset_n) c_q <= 1'b0;
            else           c_q <= crd[j];
         end
         assign crd[j+1] = c_q;
      end else begin : g_pipe
         (* shreg_extract = "no" *) logic c_q;
         always_ff @(posedge clk) begin
            if (!sreset_n) c_q <= 1'b0;
            else           c_q <= crd[j];
         end
         assign crd[j+1] = c_q;
      end
   end

   assign credit_ret = crd[L_B];

   // credits + beats in flight + FIFO occupancy + credit pulses in flight always equals FIFO_DEPTH.
   always_ff @(posedge clk) begin
      if (!sreset_n) begin
         credits <= CW'(FIFO_DEPTH);
      end else if (accept && !credit_ret) begin
         credits <= credits - 1'b1;
      end else if (!accept && credit_ret) begin
         credits <= credits + 1'b1;
      end
   end

   assign fifo_wr    = fwd_v[L_F];
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign m_valid    = !fifo_empty;
   assign m_data     = mem[rd_ptr[AW-1:0]];
   assign pop        = m_valid && m_ready;

   always_ff @(posedge clk) begin
      if (!sreset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) mem[wr_ptr[AW-1:0]] <= fwd_d[L_F];
   end

   // Credits bound the beats in flight, so a write can never land on a full FIFO.
   assert property (@(posedge clk) disable iff (!sreset_n) fifo_wr |-> !fifo_full);

endmodule

// File: tb/tb_slr_cross_stream.sv
// Bench for slr_cross_stream: a default instance and a shallow instance (REGS_BEFORE=0,
// REGS_AFTER=2, FIFO_DEPTH=4), checked against a timestamped queue model of beats and credits.
module tb_slr_cross_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        sreset_n;
   logic [15:0] a_s_data, a_m_data;
   logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready;
   logic [4:0]  a_credits;
   logic [15:0] b_s_data, b_m_data;
   logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready;
   logic [2:0]  b_credits;

   slr_cross_stream dut_a (
      .clk(clk), .sreset_n(sreset_n),
      .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
      .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
      .credits(a_credits)
   );

   slr_cross_stream #(.WIDTH(16), .REGS_BEFORE(0), .REGS_AFTER(2), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .sreset_n(sreset_n),
      .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
      .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
      .credits(b_credits)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int sel      = 0;
   int m_lf, m_lb, m_depth;
   int outstanding = 0;

   // Model: each accepted beat becomes visible at accept_cycle+L_F+1 and each pop returns its
   // credit at pop_cycle+L_B+1; outstanding counts beats whose credit has not come home yet.
   logic [15:0] fq_data[$];
   int          fq_time[$];
   int          cr_time[$];

   function automatic bit exp_m_valid();
      return (fq_data.size() > 0) && (fq_time[0] <= cyc);
   endfunction

   function automatic int exp_credits();
      return m_depth - outstanding;
   endfunction

   function automatic bit exp_s_ready();
      return sreset_n && (outstanding < m_depth);
   endfunction

   task automatic set_cfg(input int s);
      sel = s;
      if (s == 0) begin
         m_lf = 4; m_lb = 4; m_depth = 16;
      end else begin
         m_lf = 4; m_lb = 4; m_depth = 4;
      end
   endtask

   task automatic idle();
      a_s_valid = 1'b0; a_m_ready = 1'b0; a_s_data = '0;
      b_s_valid = 1'b0; b_m_ready = 1'b0; b_s_data = '0;
   endtask

   task automatic tick();
      logic sv, mr;
      logic [15:0] sd;
      bit acc, pop;
      sv  = (sel != 0) ? b_s_valid : a_s_valid;
      mr  = (sel != 0) ? b_m_ready : a_m_ready;
      sd  = (sel != 0) ? b_s_data  : a_s_data;
      acc = sreset_n && sv && (outstanding < m_depth);
      pop = sreset_n && exp_m_valid() && mr;
      if (!sreset_n) begin
         fq_data.delete(); fq_time.delete(); cr_time.delete();
         outstanding = 0;
      end else begin
         if (pop) begin
            void'(fq_data.pop_front());
            void'(fq_time.pop_front());
            cr_time.push_back(cyc + m_lb + 1);
         end
         if (acc) begin
            fq_data.push_back(sd);
            fq_time.push_back(cyc + m_lf + 1);
            outstanding++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      while ((cr_time.size() > 0) && (cr_time[0] <= cyc)) begin
         void'(cr_time.pop_front());
         outstanding--;
      end
   endtask

   task automatic do_reset();
      sreset_n = 1'b0;
      idle();
      #1;
      tick();
      sreset_n = 1'b1;
   endtask

   task automatic test_reset();
      set_cfg(0);
      sreset_n = 1'b0;
      idle();
      for (int k = 0; k < 3; k++) begin
         #1;
         tick();
      end
      #1;
      n_checks++; if (a_s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_s_ready: got %b expected 0", a_s_ready); end
      n_checks++; if (a_m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_m_valid: got %b expected 0", a_m_valid); end
      n_checks++; if (a_credits !== 5'd16) begin n_fail++; $display("FAIL reset_a_credits: got %0d expected 16", a_credits); end
      n_checks++; if (b_s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_s_ready: got %b expected 0", b_s_ready); end
      n_checks++; if (b_m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_m_valid: got %b expected 0", b_m_valid); end
      n_checks++; if (b_credits !== 3'd4) begin n_fail++; $display("FAIL reset_b_credits: got %0d expected 4", b_credits); end
      tick();
      sreset_n = 1'b1;
      #1;
      n_checks++; if (a_s_ready !== 1'b1) begin n_fail++; $display("FAIL release_a_s_ready: got %b expected 1", a_s_ready); end
      n_checks++; if (b_s_ready !== 1'b1) begin n_fail++; $display("FAIL release_b_s_ready: got %b expected 1", b_s_ready); end
      n_checks++; if (a_credits !== 5'd16) begin n_fail++; $display("FAIL release_a_credits: got %0d expected 16", a_credits); end
      tick();
   endtask

   task automatic test_latency();
      logic ev;
      logic [4:0] ec;
      set_cfg(0);
      do_reset();
      for (int rel = 0; rel < 26; rel++) begin
         a_s_valid = (rel == 10);
         a_s_data  = 16'hA5A5;
         a_m_ready = 1'b1;
         #1;
         ev = (rel == 15);
         ec = ((rel >= 11) && (rel <= 19)) ? 5'd15 : 5'd16;
         n_checks++; if (a_m_valid !== ev) begin n_fail++; $display("FAIL latency_m_valid: cycle %0d got %b expected %b", rel, a_m_valid, ev); end
         if (rel == 15) begin
            n_checks++; if (a_m_data !== 16'hA5A5) begin n_fail++; $display("FAIL latency_m_data: got %h expected a5a5", a_m_data); end
         end
         n_checks++; if (a_credits !== ec) begin n_fail++; $display("FAIL latency_credits: cycle %0d got %0d expected %0d", rel, a_credits, ec); end
         tick();
      end
   endtask

   task automatic test_full_throughput();
      int nxt, got;
      logic ev;
      set_cfg(0);
      do_reset();
      nxt = 0;
      got = 0;
      for (int k = 0; (k < 1300) && (got < 1000); k++) begin
         a_s_valid = (nxt < 1000);
         a_s_data  = 16'(nxt);
         a_m_ready = 1'b1;
         #1;
         if (nxt < 1000) begin
            n_checks++; if (a_s_ready !== 1'b1) begin n_fail++; $display("FAIL thru_s_ready: beat %0d got %b expected 1", nxt, a_s_ready); end
         end
         ev = exp_m_valid() || ((got > 0) && (got < 1000));
         n_checks++; if (a_m_valid !== ev) begin n_fail++; $display("FAIL thru_m_valid: cycle %0d got %b expected %b", k, a_m_valid, ev); end
         if (ev) begin
            n_checks++; if (a_m_data !== 16'(got)) begin n_fail++; $display("FAIL thru_m_data: got %0d expected %0d", a_m_data, got); end
            got++;
         end
         if ((nxt < 1000) && exp_s_ready()) nxt++;
         tick();
      end
      n_checks++; if (got != 1000) begin n_fail++; $display("FAIL thru_count: got %0d expected 1000", got); end
   endtask

   task automatic test_backpressure_fill();
      int acc_seen;
      logic [15:0] beat0;
      logic ev;
      set_cfg(0);
      do_reset();
      acc_seen = 0;
      beat0 = '0;
      for (int k = 0; k < 30; k++) begin
         a_s_valid = 1'b1;
         a_s_data  = 16'($urandom);
         a_m_ready = 1'b0;
         if (k == 0) beat0 = a_s_data;
         #1;
         n_checks++; if (a_s_ready !== exp_s_ready()) begin n_fail++; $display("FAIL fill_s_ready: cycle %0d got %b expected %b", k, a_s_ready, exp_s_ready()); end
         n_checks++; if (a_credits !== 5'(exp_credits())) begin n_fail++; $display("FAIL fill_credits: cycle %0d got %0d expected %0d", k, a_credits, exp_credits()); end
         if (a_s_ready === 1'b1) acc_seen++;
         tick();
      end
      n_checks++; if (acc_seen != 16) begin n_fail++; $display("FAIL fill_accepted: got %0d expected 16", acc_seen); end
      a_s_valid = 1'b0;
      #1;
      n_checks++; if (a_m_valid !== 1'b1) begin n_fail++; $display("FAIL fill_m_valid: got %b expected 1", a_m_valid); end
      n_checks++; if (a_m_data !== beat0) begin n_fail++; $display("FAIL fill_head: got %h expected %h", a_m_data, beat0); end
      for (int rel = 0; rel < 40; rel++) begin
         a_m_ready = 1'b1;
         if (rel > 0) #1;
         if (rel <= 5) begin
            n_checks++; if (a_s_ready !== (rel == 5)) begin n_fail++; $display("FAIL drain_s_ready: cycle %0d got %b expected %b", rel, a_s_ready, rel == 5); end
         end
         ev = exp_m_valid();
         n_checks++; if (a_m_valid !== ev) begin n_fail++; $display("FAIL drain_m_valid: cycle %0d got %b expected %b", rel, a_m_valid, ev); end
         if (ev) begin
            n_checks++; if (a_m_data !== fq_data[0]) begin n_fail++; $display("FAIL drain_m_data: got %h expected %h", a_m_data, fq_data[0]); end
         end
         tick();
      end
      #1;
      n_checks++; if (a_credits !== 5'd16) begin n_fail++; $display("FAIL drain_credits: got %0d expected 16", a_credits); end
   endtask

   task automatic test_random_small();
      logic ev;
      set_cfg(1);
      do_reset();
      for (int k = 0; k < 840; k++) begin
         if (k < 800) begin
            b_s_valid = ($urandom_range(0, 3) != 0);
            b_s_data  = 16'($urandom);
            if (k < 300)      b_m_ready = ($urandom_range(0, 1) != 0);
            else if (k < 550) b_m_ready = ($urandom_range(0, 9) != 0);
            else              b_m_ready = ($urandom_range(0, 9) == 0);
         end else begin
            b_s_valid = 1'b0;
            b_m_ready = 1'b1;
         end
         #1;
         ev = exp_m_valid();
         n_checks++; if (b_s_ready !== exp_s_ready()) begin n_fail++; $display("FAIL rand_s_ready: cycle %0d got %b expected %b", k, b_s_ready, exp_s_ready()); end
         n_checks++; if (b_credits !== 3'(exp_credits())) begin n_fail++; $display("FAIL rand_credits: cycle %0d got %0d expected %0d", k, b_credits, exp_credits()); end
         n_checks++; if (b_m_valid !== ev) begin n_fail++; $display("FAIL rand_m_valid: cycle %0d got %b expected %b", k, b_m_valid, ev); end
         if (ev) begin
            n_checks++; if (b_m_data !== fq_data[0]) begin n_fail++; $display("FAIL rand_m_data: cycle %0d got %h expected %h", k, b_m_data, fq_data[0]); end
         end
         tick();
      end
      idle();
   endtask

   task automatic test_reset_midstream();
      set_cfg(0);
      do_reset();
      for (int k = 0; k < 8; k++) begin
         a_s_valid = 1'b1;
         a_s_data  = 16'h0100 + 16'(k);
         a_m_ready = 1'b0;
         #1;
         tick();
      end
      a_s_valid = 1'b0;
      sreset_n  = 1'b0;
      #1;
      tick();
      sreset_n = 1'b1;
      #1;
      n_checks++; if (a_m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid: got %b expected 0", a_m_valid); end
      n_checks++; if (a_credits !== 5'd16) begin n_fail++; $display("FAIL midrst_credits: got %0d expected 16", a_credits); end
      n_checks++; if (a_s_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_s_ready: got %b expected 1", a_s_ready); end
      for (int k = 0; k < 20; k++) begin
         a_m_ready = 1'b1;
         if (k > 0) #1;
         n_checks++; if (a_m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: cycle %0d got m_valid %b data %h expected 0", k, a_m_valid, a_m_data); end
         tick();
      end
   endtask

   task automatic test_simultaneous();
      set_cfg(0);
      do_reset();
      for (int k = 0; k < 15; k++) begin
         a_s_valid = 1'b1;
         a_s_data  = 16'($urandom);
         #1;
         tick();
      end
      a_s_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         tick();
      end
      for (int rel = 0; rel < 7; rel++) begin
         a_m_ready = (rel == 0);
         a_s_valid = (rel == 4);
         a_s_data  = 16'h5A5A;
         #1;
         n_checks++; if (a_credits !== 5'd1) begin n_fail++; $display("FAIL simul_credits: cycle %0d got %0d expected 1", rel, a_credits); end
         n_checks++; if (a_s_ready !== 1'b1) begin n_fail++; $display("FAIL simul_s_ready: cycle %0d got %b expected 1", rel, a_s_ready); end
         n_checks++; if (a_credits !== 5'(exp_credits())) begin n_fail++; $display("FAIL simul_model: cycle %0d got %0d expected %0d", rel, a_credits, exp_credits()); end
         tick();
      end
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      sreset_n = 1'b0;
      idle();
      set_cfg(0);
      test_reset();
      test_latency();
      test_full_throughput();
      test_backpressure_fill();
      test_random_small();
      test_reset_midstream();
      test_simultaneous();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
